// File: rtl/param_ram_pkg.sv
// Shared types and elaboration-time helpers for the parametrised program/data RAM.
package param_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // A single-word array still needs a one-bit index to stay legal.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit params_ok(input int data_w, input int addr_w, input int depth);
    return (data_w > 0) && (data_w % 8 == 0) && (depth > 0) &&
           (longint'(depth) <= (longint'(1) << addr_w));
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: sweeps zeros through every word, holding busy until done.
module ram_clear_seq
  import param_ram_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int IDX_W          = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             o_busy,
  output logic             o_clr_we,
  output logic [IDX_W-1:0] o_clr_addr
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_clr_ptr;
  logic [IDX_W-1:0]   w_clr_ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    o_clr_we      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        // rst alone must never touch the array, so the sweep write waits for release.
        o_clr_we = ~rst;
        if (r_clr_ptr == IDX_W'(DEPTH - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_clr_ptr_nxt = '0;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_busy     = (r_state == ST_CLEAR);
  assign o_clr_addr = r_clr_ptr;

endmodule

// File: rtl/param_ram.sv
// Single-port synchronous RAM with byte enables, optional output register,
// read-valid strobe, out-of-range detection and post-reset clear.
module param_ram
  import param_ram_pkg::*;
#(
  parameter int    DATA_W         = 16,
  parameter int    ADDR_W         = 11,
  parameter int    DEPTH          = 64,
  parameter int    OUT_REG        = 0,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W/8-1:0]   byte_en,
  input  logic                  rd,
  input  logic                  wr,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  addr_err
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int IDX_W = idx_w(DEPTH);

  if (!params_ok(DATA_W, ADDR_W, DEPTH)) begin : g_bad_params
    $error("param_ram: DATA_W must be a multiple of 8 and DEPTH <= 2**ADDR_W");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic             w_busy;
  logic             w_clr_we;
  logic [IDX_W-1:0] w_clr_addr;
  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;
  logic             w_rd_acc;
  logic             w_wr_acc;

  ram_clear_seq #(
    .DEPTH          (DEPTH),
    .IDX_W          (IDX_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // Full-width compare so high address bits flag an error instead of aliasing.
  assign w_in_range = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));
  assign w_idx      = address[IDX_W-1:0];
  assign w_rd_acc   = rd & ~w_busy & ~rst;
  assign w_wr_acc   = wr & ~rd & ~w_busy & ~rst & (|byte_en);

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_acc && w_in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byte_en[i]) r_mem[w_idx][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  // ---- stage p0: array read, request strobes ----
  logic [DATA_W-1:0] r_data_p0;
  logic              r_vld_p0;
  logic              r_rerr_p0;
  logic              r_werr_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_p0 <= '0;
      r_vld_p0  <= 1'b0;
      r_rerr_p0 <= 1'b0;
      r_werr_p0 <= 1'b0;
    end else begin
      r_vld_p0  <= w_rd_acc;
      r_rerr_p0 <= w_rd_acc & ~w_in_range;
      r_werr_p0 <= w_wr_acc & ~w_in_range;
      if (w_rd_acc) r_data_p0 <= w_in_range ? r_mem[w_idx] : '0;
    end
  end

  // ---- stage p1: optional output register ----
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] r_data_p1;
    logic              r_vld_p1;
    logic              r_rerr_p1;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_data_p1 <= '0;
        r_vld_p1  <= 1'b0;
        r_rerr_p1 <= 1'b0;
      end else begin
        r_vld_p1  <= r_vld_p0;
        r_rerr_p1 <= r_rerr_p0;
        if (r_vld_p0) r_data_p1 <= r_data_p0;
      end
    end

    // Write errors are not delayed: they always pulse the cycle after acceptance.
    assign data_out = r_data_p1;
    assign rd_valid = r_vld_p1;
    assign addr_err = r_rerr_p1 | r_werr_p0;
  end else begin : g_no_out_reg
    assign data_out = r_data_p0;
    assign rd_valid = r_vld_p0;
    assign addr_err = r_rerr_p0 | r_werr_p0;
  end

  assign busy = w_busy;

endmodule

// File: tb/tb_param_ram.sv
// Scoreboard bench for param_ram: two instances (OUT_REG=0 and OUT_REG=1) share stimulus.
module tb_param_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] address = '0;
  logic [15:0] data_in = '0;
  logic [1:0]  byte_en = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;

  logic [15:0] dout0, dout1;
  logic        vld0, vld1, busy0, busy1, err0, err1;

  typedef struct {
    bit          is_rd;
    logic [15:0] data;
    bit          err;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_ram #(
    .DATA_W(16), .ADDR_W(11), .DEPTH(64), .OUT_REG(0), .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) dut0 (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .byte_en(byte_en),
    .rd(rd), .wr(wr), .data_out(dout0), .rd_valid(vld0), .busy(busy0), .addr_err(err0)
  );

  param_ram #(
    .DATA_W(16), .ADDR_W(11), .DEPTH(64), .OUT_REG(1), .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .byte_en(byte_en),
    .rd(rd), .wr(wr), .data_out(dout1), .rd_valid(vld1), .busy(busy1), .addr_err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon(input int id, input logic v, input logic e, input logic [15:0] d);
    exp_t x;
    if (v !== 1'b1 && e !== 1'b1) return;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      chk($sformatf("dut%0d_unexpected_strobe{vld,err}", id), {30'd0, v, e}, 32'd0);
      return;
    end
    if (id == 0) x = q0.pop_front();
    else         x = q1.pop_front();
    chk($sformatf("dut%0d_strobe_cycle", id), cyc, x.due);
    chk($sformatf("dut%0d_rd_valid", id), {31'd0, v}, {31'd0, x.is_rd});
    chk($sformatf("dut%0d_addr_err", id), {31'd0, e}, {31'd0, x.err});
    if (x.is_rd) chk($sformatf("dut%0d_data_out", id), {16'd0, d}, {16'd0, x.data});
  endtask

  always @(negedge clk) begin
    mon(0, vld0, err0, dout0);
    mon(1, vld1, err1, dout1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_rd, input logic [15:0] d, input bit e);
    q0.push_back('{is_rd, d, e, cyc + 1});
    q1.push_back('{is_rd, d, e, cyc + 1 + (is_rd ? 1 : 0)});
  endtask

  task automatic do_rd(input logic [10:0] a, input logic [15:0] exp_d, input bit exp_e);
    address = a;
    rd = 1'b1;
    push(1'b1, exp_d, exp_e);
    cycle();
    rd = 1'b0;
  endtask

  task automatic do_wr(input logic [10:0] a, input logic [15:0] d, input logic [1:0] be,
                       input bit exp_e);
    address = a;
    data_in = d;
    byte_en = be;
    wr = 1'b1;
    if (exp_e) push(1'b0, 16'h0000, 1'b1);
    cycle();
    wr = 1'b0;
    byte_en = '0;
  endtask

  // Counts sampled busy cycles; optionally drives dropped reads during the first cycles.
  task automatic count_busy(output int n, input int rd_cycles);
    n = 0;
    while (busy0 === 1'b1 && n < 200) begin
      rd = (n < rd_cycles);
      address = 11'(n * 5);
      n++;
      cycle();
    end
    rd = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] exp_mem [64];

    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_dout0", {16'd0, dout0}, 32'd0);
    chk("rst_dout1", {16'd0, dout1}, 32'd0);
    chk("rst_vld0", {31'd0, vld0}, 32'd0);
    chk("rst_vld1", {31'd0, vld1}, 32'd0);
    chk("rst_err0", {31'd0, err0}, 32'd0);
    chk("rst_err1", {31'd0, err1}, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd1);
    chk("rst_busy1", {31'd0, busy1}, 32'd1);
    rst = 1'b0;

    // Test 1: clear lasts DEPTH cycles, then read address 10
    count_busy(n, 0);
    chk("clear_busy_cycles", n, 32'd64);
    chk("clear_busy1_done", {31'd0, busy1}, 32'd0);
    do_rd(11'd10, 16'h0000, 1'b0);
    cycle(); cycle(); cycle();

    // Test 2: byte-enable merge
    do_wr(11'd0, 16'h180A, 2'b11, 1'b0);
    do_wr(11'd0, 16'hFF00, 2'b01, 1'b0);
    do_rd(11'd0, 16'h1800, 1'b0);
    cycle(); cycle(); cycle();
    chk("hold_dout0", {16'd0, dout0}, 32'h1800);
    chk("hold_vld0", {31'd0, vld0}, 32'd0);
    chk("hold_dout1", {16'd0, dout1}, 32'h1800);
    chk("hold_vld1", {31'd0, vld1}, 32'd0);

    // Test 3: back-to-back reads
    do_wr(11'd10, 16'h0009, 2'b11, 1'b0);
    do_wr(11'd11, 16'hFFFC, 2'b11, 1'b0);
    do_wr(11'd12, 16'h0000, 2'b11, 1'b0);
    cycle();
    do_rd(11'd10, 16'h0009, 1'b0);
    do_rd(11'd11, 16'hFFFC, 1'b0);
    do_rd(11'd12, 16'h0000, 1'b0);
    cycle(); cycle(); cycle();

    // Write immediately followed by read of the same word; byte_en=0 writes are no-ops
    do_wr(11'd7, 16'hA55A, 2'b11, 1'b0);
    do_rd(11'd7, 16'hA55A, 1'b0);
    do_wr(11'd20, 16'hFFFF, 2'b00, 1'b0);
    do_wr(11'd100, 16'hFFFF, 2'b00, 1'b0);
    do_rd(11'd20, 16'h0000, 1'b0);
    cycle(); cycle(); cycle();

    // Test 4: simultaneous rd and wr -> read only
    do_wr(11'd5, 16'h3005, 2'b11, 1'b0);
    address = 11'd5;
    data_in = 16'hBEEF;
    byte_en = 2'b11;
    rd = 1'b1;
    wr = 1'b1;
    push(1'b1, 16'h3005, 1'b0);
    cycle();
    rd = 1'b0;
    wr = 1'b0;
    byte_en = '0;
    do_rd(11'd5, 16'h3005, 1'b0);
    cycle(); cycle(); cycle();

    // Test 5: out-of-range accesses, including high address bits
    do_rd(11'd64, 16'h0000, 1'b1);
    cycle(); cycle();
    do_wr(11'd100, 16'h1234, 2'b11, 1'b1);
    cycle(); cycle();
    do_rd(11'h440, 16'h0000, 1'b1);
    cycle(); cycle();
    do_wr(11'd69, 16'hFFFF, 2'b11, 1'b1);
    cycle(); cycle();
    do_rd(11'd2047, 16'h0000, 1'b1);
    cycle(); cycle();

    for (int i = 0; i < 64; i++) exp_mem[i] = 16'h0000;
    exp_mem[0]  = 16'h1800;
    exp_mem[5]  = 16'h3005;
    exp_mem[7]  = 16'hA55A;
    exp_mem[10] = 16'h0009;
    exp_mem[11] = 16'hFFFC;
    for (int i = 0; i < 64; i++) do_rd(11'(i), exp_mem[i], 1'b0);
    cycle(); cycle(); cycle();

    // Test 6: reset restarted mid-clear; reads during busy are dropped
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    repeat (30) cycle();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    count_busy(n, 4);
    chk("restart_busy_cycles", n, 32'd64);
    for (int i = 0; i < 64; i++) do_rd(11'(i), 16'h0000, 1'b0);
    cycle(); cycle(); cycle();

    chk("scoreboard0_drained", q0.size(), 32'd0);
    chk("scoreboard1_drained", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
